mips_mem_loader: RTL and testbench

Parametrised boot loader for the MIPS core: holds the core in reset, optionally zero-fills instruction and data memories, then accepts a valid/ready stream of word writes into either memory before releasing the core. It replaces bench-side hierarchical memory pokes with a synthesizable front end between the host/bench and the `InstructionMemory` / `DataMemory` write ports.

---
 rtl/mips_mem_loader.sv | 155 +++++++++++++++
 tb/tb_mips_mem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_loader.sv
// Boot loader front end for the MIPS core: holds the core in reset, optionally zero-fills
// both memories (MEM_LOADER_CLEAR_EN), streams word writes in, then releases the core.
module mips_mem_loader #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int ADDR_W     = $clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

    localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_DEPTH);

`ifdef MEM_LOADER_CLEAR_EN
    localparam int              MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_DEPTH - 1);
    localparam state_t          ENTRY     = S_CLEAR;
    logic [ADDR_W-1:0] c_q, c_d;
    logic              clearing;
`else
    localparam state_t          ENTRY     = S_LOAD;
`endif

    state_t            state_q, state_d;
    logic              live_q;
    logic              err_q, err_d;
    logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              xfer, in_range;

    assign ld_ready = (state_q == S_LOAD) && live_q;
    assign xfer     = ld_valid && ld_ready;
    assign in_range = ld_sel ? ({1'b0, ld_addr} < DMEM_LIM) : ({1'b0, ld_addr} < IMEM_LIM);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        imem_we_d = 1'b0;
        dmem_we_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef MEM_LOADER_CLEAR_EN
        c_d       = c_q;
`endif
        case (state_q)
            S_CLEAR: begin
`ifdef MEM_LOADER_CLEAR_EN
                // live_q keeps the sweep parked at 0 while reset is held
                if (live_q) begin
                    c_d = c_q + 1'b1;
                    if (c_q == CLR_LAST) begin
                        c_d     = '0;
                        state_d = S_LOAD;
                    end
                end
`else
                state_d = S_LOAD;
`endif
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_addr_d = ld_addr;
                    wr_data_d = ld_data;
                    if (in_range) begin
                        imem_we_d = ~ld_sel;
                        dmem_we_d = ld_sel;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (ld_last) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    state_d = ENTRY;
                    err_d   = 1'b0;
`ifdef MEM_LOADER_CLEAR_EN
                    c_d     = '0;
`endif
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ENTRY;
            live_q    <= 1'b0;
            err_q     <= 1'b0;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef MEM_LOADER_CLEAR_EN
            c_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            err_q     <= err_d;
            imem_we_q <= imem_we_d;
            dmem_we_q <= dmem_we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef MEM_LOADER_CLEAR_EN
            c_q       <= c_d;
`endif
        end
    end

`ifdef MEM_LOADER_CLEAR_EN
    // Sweep writes come straight off the counter so addr 0 lands in the entry cycle
    assign clearing   = (state_q == S_CLEAR) && live_q;
    assign imem_we    = clearing ? ({1'b0, c_q} < IMEM_LIM) : imem_we_q;
    assign dmem_we    = clearing ? ({1'b0, c_q} < DMEM_LIM) : dmem_we_q;
    assign imem_addr  = clearing ? c_q : wr_addr_q;
    assign dmem_addr  = clearing ? c_q : wr_addr_q;
    assign imem_wdata = clearing ? '0 : wr_data_q;
    assign dmem_wdata = clearing ? '0 : wr_data_q;
`else
    assign imem_we    = imem_we_q;
    assign dmem_we    = dmem_we_q;
    assign imem_addr  = wr_addr_q;
    assign dmem_addr  = wr_addr_q;
    assign imem_wdata = wr_data_q;
    assign dmem_wdata = wr_data_q;
`endif

    assign cpu_rst = (state_q == S_RUN);
    assign busy    = (state_q != S_RUN);
    assign err     = err_q;

endmodule

// File: tb/tb_mips_mem_loader.sv
// Scoreboard bench for mips_mem_loader: stimulus pushes expected writes (with their
// expected cycle), a negedge monitor pops and compares. Works with or without MEM_LOADER_CLEAR_EN.
module tb_mips_mem_loader;
    localparam int IMEM_D = 8;
    localparam int DMEM_D = 16;
    localparam int AW     = 4;
    localparam int DW     = 32;
`ifdef MEM_LOADER_CLEAR_EN
    localparam int CLR_N  = 16;
`else
    localparam int CLR_N  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic          ld_sel = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          imem_we, dmem_we;
    logic [AW-1:0] imem_addr, dmem_addr;
    logic [DW-1:0] imem_wdata, dmem_wdata;
    logic          cpu_rst, busy, err;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic model_err = 1'b0;

    typedef struct {
        logic          iwe;
        logic          dwe;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
        logic          crst;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    mips_mem_loader #(.DATA_W(DW), .IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any expected write whose cycle has passed was missed; any write must match the head.
    always @(negedge clk) begin
        if (rst) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                chk("missed_write", 64'(cyc), 64'(mon_e.cyc));
            end
            if (imem_we || dmem_we) begin
                if (expq.size() == 0) begin
                    chk("unexpected_write", 64'({imem_we, dmem_we}), 64'(0));
                end else begin
                    mon_e = expq.pop_front();
                    chk("write_sel",   64'({imem_we, dmem_we}), 64'({mon_e.iwe, mon_e.dwe}));
                    chk("write_addr",  64'(imem_we ? imem_addr : dmem_addr), 64'(mon_e.addr));
                    chk("write_data",  64'(imem_we ? imem_wdata : dmem_wdata), 64'(mon_e.data));
                    chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("cpu_rst_at_write", 64'(cpu_rst), 64'(mon_e.crst));
                end
            end
        end
    end

    task automatic push_clear(input int b);
        for (int c = 0; c < CLR_N; c++)
            expq.push_back('{(c < IMEM_D), (c < DMEM_D), AW'(c), '0, b + c, 1'b0});
    endtask

    task automatic wait_ready(input int expc);
        int k = 0;
        while (!ld_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_cycle", 64'(cyc), 64'(expc));
    endtask

    task automatic do_reset();
        int r;
        rst = 1'b0; ld_valid = 1'b0; start = 1'b0;
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rst",  64'(cpu_rst), 64'(0));
        chk("rst_busy",     64'(busy), 64'(1));
        chk("rst_err",      64'(err), 64'(0));
        chk("rst_we",       64'({imem_we, dmem_we}), 64'(0));
        chk("rst_ld_ready", 64'(ld_ready), 64'(0));
        chk("rst_addr",     64'({imem_addr, dmem_addr}), 64'(0));
        chk("rst_wdata",    64'(imem_wdata | dmem_wdata), 64'(0));
        rst = 1'b1;
        r = cyc;
        model_err = 1'b0;
        push_clear(r + 1);
        wait_ready(r + 1 + CLR_N);
    endtask

    task automatic send(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic last);
        logic hs;
        int   k = 0;
        ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data; ld_last = last;
        do begin
            @(negedge clk); hs = ld_ready;
            @(posedge clk); #1;
            k++;
        end while (!hs && k < 100);
        if (!hs) chk("handshake_timeout", 64'(k), 64'(0));
        ld_valid = 1'b0; ld_last = 1'b0;
        if ((sel ? int'(addr) < DMEM_D : int'(addr) < IMEM_D))
            expq.push_back('{~sel, sel, addr, data, cyc, last});
        else
            model_err = 1'b1;
    endtask

    // Idle cycles with junk on the bus and random start pulses, all of which must be ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b0;
            ld_sel   = 1'($urandom_range(0, 1));
            ld_addr  = AW'($urandom_range(0, 15));
            ld_data  = $urandom;
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("load_held", 64'({busy, cpu_rst}), 64'(2'b10));
    endtask

    task automatic end_image();
        repeat (2) @(posedge clk);
        #1;
        chk("run_cpu_rst",  64'(cpu_rst), 64'(1));
        chk("run_busy",     64'(busy), 64'(0));
        chk("run_ld_ready", 64'(ld_ready), 64'(0));
        chk("run_err",      64'(err), 64'(model_err));
    endtask

    task automatic restart();
        int m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = cyc;
        push_clear(m);
        chk("start_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("start_busy",    64'(busy), 64'(1));
        chk("start_err",     64'(err), 64'(0));
        model_err = 1'b0;
        wait_ready(m + CLR_N);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        send(1'b0, 4'd1, 32'h0000_0820, 1'b0);
        send(1'b0, 4'd2, 32'h2402_000A, 1'b0);
        send(1'b1, 4'd3, 32'd7, 1'b1);
        end_image();
        restart();

        send(1'b0, 4'd8, 32'hDEAD_BEEF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_after_oob", 64'(err), 64'(1));
        send(1'b1, 4'd8, 32'h1234_5678, 1'b0);
        send(1'b0, 4'd5, 32'hA5A5_0001, 1'b0);
        gap(1);
        send(1'b0, 4'd6, 32'hA5A5_0002, 1'b1);
        end_image();
        restart();

        for (int img = 0; img < 6; img++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int b = 0; b < n; b++) begin
                send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, (b == n - 1));
                if (b != n - 1 && $urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
            end
            end_image();
            restart();
        end

        send(1'b0, 4'd3, 32'hCAFE_F00D, 1'b0);
        rst = 1'b0;
        #1;
        expq.delete();
        chk("abort_we",      64'({imem_we, dmem_we}), 64'(0));
        chk("abort_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("abort_busy",    64'(busy), 64'(1));
        do_reset();
        send(1'b1, 4'd15, 32'h0BAD_CAFE, 1'b1);
        end_image();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(expq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
